// File: rtl/mem_stage.sv
// mem_stage: LC-3b MEM stage with data-memory handshake, LDI/STI indirection and MEM/WB register.
//   Inputs : clk, reset (async, active-high), exmem_* instruction fields, mem_rd/mem_wr/mem_byte/mem_ind
//            decode flags, dmem_rdata/dmem_resp from data memory.
//   Outputs: dmem_read/dmem_write/dmem_address/dmem_wdata/dmem_byte_en request, stall_out to upstream,
//            mem_timeout watchdog pulse, wb_* MEM/WB register fields.
//   Param  : MAX_WAIT request cycles per phase before abort (0 disables the watchdog).
//   Macro  : UNALIGNED_TRAP_EN adds a misalign output and traps odd word addresses instead of clearing addr[0].
module mem_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exmem_valid,
    input  logic [15:0] exmem_addr,
    input  logic [15:0] exmem_sdata,
    input  logic [15:0] exmem_pc,
    input  logic [15:0] exmem_ir,
    input  logic [7:0]  exmem_ctrl,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        mem_byte,
    input  logic        mem_ind,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_en,
    output logic        stall_out,
    output logic        mem_timeout,
    output logic        wb_valid,
    output logic [15:0] wb_alu_out,
    output logic [15:0] wb_mem_data,
    output logic [15:0] wb_pc,
    output logic [15:0] wb_ir,
    output logic [7:0]  wb_ctrl
`ifdef UNALIGNED_TRAP_EN
    ,
    output logic        misalign
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, IND2, DONE} state_t;
`ifdef UNALIGNED_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [15:0] WLIM = 16'(MAX_WAIT - 1);
    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [14:0] ptr_q, ptr_d;
    logic [15:0] data_q, data_d;
    logic        timeout_q, timeout_d;
    logic        misalign_q, misalign_d;
    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_alu_q, wb_data_q, wb_pc_q, wb_ir_q;
    logic [7:0]  wb_ctrl_q, wb_ctrl_d;
    logic        mem_op, req, ph1, abort, odd, byte_st;
    assign mem_op  = exmem_valid & (mem_rd | mem_wr);
    // An aborted instruction is still held upstream for one cycle; this keeps it from restarting.
    assign abort   = timeout_q | misalign_q;
    assign ph1     = state_q == ACCESS;
    assign req     = ph1 | (state_q == IND2);
    assign odd     = TRAP & ~mem_byte & exmem_addr[0];
    // Phase 1 of LDI/STI always reads the pointer; the second phase performs the real access.
    assign dmem_read    = (ph1 & (mem_rd | mem_ind)) | ((state_q == IND2) & mem_rd);
    assign dmem_write   = (ph1 & mem_wr & ~mem_ind) | ((state_q == IND2) & mem_wr);
    assign byte_st      = dmem_write & ph1 & mem_byte;
    assign dmem_address = req ? {(state_q == IND2) ? ptr_q : exmem_addr[15:1], 1'b0} : 16'h0000;
    assign dmem_wdata   = ~dmem_write ? 16'h0000 : byte_st ? {2{exmem_sdata[7:0]}} : exmem_sdata;
    assign dmem_byte_en = ~req ? 2'b00 : byte_st ? (exmem_addr[0] ? 2'b10 : 2'b01) : 2'b11;
    assign stall_out    = mem_op & (state_q != DONE) & ~abort;
    assign mem_timeout  = timeout_q;
`ifdef UNALIGNED_TRAP_EN
    assign misalign     = misalign_q;
`endif
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        timeout_d  = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: if (mem_op && !abort) begin
                wait_d = '0;
                if (odd) misalign_d = 1'b1;
                else state_d = ACCESS;
            end
            ACCESS, IND2: if (dmem_resp) begin
                wait_d = '0;
                if (ph1 && mem_ind) begin
                    ptr_d = dmem_rdata[15:1];
                    misalign_d = TRAP & dmem_rdata[0];
                    state_d = (TRAP && dmem_rdata[0]) ? IDLE : IND2;
                end else begin
                    data_d  = !mem_byte ? dmem_rdata : {8'h00, exmem_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]};
                    state_d = DONE;
                end
            end else if (MAX_WAIT != 0 && wait_q == WLIM) begin
                timeout_d = 1'b1;
                state_d   = IDLE;
            end else begin
                wait_d = wait_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    assign wb_valid_d = exmem_valid & ~stall_out & ~abort;
    assign wb_ctrl_d  = wb_valid_d ? exmem_ctrl : 8'h00;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            ptr_q      <= '0;
            data_q     <= '0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_alu_q   <= '0;
            wb_data_q  <= '0;
            wb_pc_q    <= '0;
            wb_ir_q    <= '0;
            wb_ctrl_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            timeout_q  <= timeout_d;
            misalign_q <= misalign_d;
            wb_valid_q <= wb_valid_d;
            wb_alu_q   <= exmem_addr;
            wb_data_q  <= data_q;
            wb_pc_q    <= exmem_pc;
            wb_ir_q    <= exmem_ir;
            wb_ctrl_q  <= wb_ctrl_d;
        end
    end
    assign wb_valid    = wb_valid_q;
    assign wb_alu_out  = wb_alu_q;
    assign wb_mem_data = wb_data_q;
    assign wb_pc       = wb_pc_q;
    assign wb_ir       = wb_ir_q;
    assign wb_ctrl     = wb_ctrl_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors, reset/timeout sequences and random ops against a transaction-level model.
module tb_mem_stage;
    localparam int MW = 4;
    typedef enum int {NOP, LDR, LDB, STR, STB, LDI, STI} op_e;
    typedef struct {logic wr; logic [15:0] a; logic [15:0] d; logic [1:0] be;} req_t;
    typedef struct {
        op_e op; logic [15:0] a, sd; int lat;
        logic [15:0] pa, pd, qa, qd;
        int es; logic [15:0] ed, la, lwd; logic [1:0] lbe; int n; bit eto;
    } vec_t;
    logic        clk, reset;
    logic        exmem_valid, mem_rd, mem_wr, mem_byte, mem_ind, dmem_resp;
    logic [15:0] exmem_addr, exmem_sdata, exmem_pc, exmem_ir, dmem_rdata;
    logic [7:0]  exmem_ctrl;
    logic        dmem_read, dmem_write, stall_out, mem_timeout, wb_valid;
    logic [15:0] dmem_address, dmem_wdata, wb_alu_out, wb_mem_data, wb_pc, wb_ir;
    logic [1:0]  dmem_byte_en;
    logic [7:0]  wb_ctrl;
    int tests = 0, fails = 0;
    int reqcnt = 0, lat_cur = 1;
    logic [15:0] mem [int];
    req_t log_q[$], exp_q[$];
    logic [15:0] cur_pc, cur_ir;
    logic [7:0]  cur_ctrl;
    vec_t tv[11];

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .exmem_valid(exmem_valid), .exmem_addr(exmem_addr),
        .exmem_sdata(exmem_sdata), .exmem_pc(exmem_pc), .exmem_ir(exmem_ir), .exmem_ctrl(exmem_ctrl),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte(mem_byte), .mem_ind(mem_ind),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
        .stall_out(stall_out), .mem_timeout(mem_timeout), .wb_valid(wb_valid), .wb_alu_out(wb_alu_out),
        .wb_mem_data(wb_mem_data), .wb_pc(wb_pc), .wb_ir(wb_ir), .wb_ctrl(wb_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mrd(input logic [15:0] a);
        int k = int'(a[15:1]);
        return mem.exists(k) ? mem[k] : ({a[15:1], 1'b0} * 16'h9E37) ^ 16'hC3A5;
    endfunction

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        mem[int'(a[15:1])] = d;
    endtask

    task automatic mwr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] o = mrd(a);
        if (be[1]) o[15:8] = d[15:8];
        if (be[0]) o[7:0] = d[7:0];
        poke(a, o);
    endtask

    // Memory responder: answers on the lat_cur-th cycle of each request, spurious resp when idle.
    task automatic service();
        req_t r;
        if (dmem_read || dmem_write) begin
            reqcnt++;
            if (reqcnt == 1) begin
                r.wr = dmem_write; r.a = dmem_address; r.d = dmem_wdata; r.be = dmem_byte_en;
                log_q.push_back(r);
            end
            if (lat_cur != 0 && reqcnt == lat_cur) begin
                dmem_resp  = 1'b1;
                dmem_rdata = dmem_read ? mrd(dmem_address) : 16'($urandom);
                if (dmem_write) mwr(dmem_address, dmem_wdata, dmem_byte_en);
                reqcnt = 0;
            end else begin
                dmem_resp  = 1'b0;
                dmem_rdata = 16'($urandom);
            end
        end else begin
            reqcnt     = 0;
            dmem_resp  = 1'($urandom);
            dmem_rdata = 16'($urandom);
        end
    endtask

    task automatic drive(input op_e op, input logic [15:0] a, input logic [15:0] sd);
        cur_pc = 16'($urandom); cur_ir = 16'($urandom); cur_ctrl = 8'($urandom_range(1, 255));
        exmem_valid = 1'b1; exmem_addr = a; exmem_sdata = sd;
        exmem_pc = cur_pc; exmem_ir = cur_ir; exmem_ctrl = cur_ctrl;
        mem_rd   = op inside {LDR, LDB, LDI};
        mem_wr   = op inside {STR, STB, STI};
        mem_byte = op inside {LDB, STB};
        mem_ind  = op inside {LDI, STI};
    endtask

    task automatic release_in();
        exmem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_byte = 1'b0; mem_ind = 1'b0;
    endtask

    task automatic run(input op_e op, input logic [15:0] a, input logic [15:0] sd, input int lat,
                       output int stalls, output bit to_seen, output bit bub_bad);
        bit s = 1'b1;
        lat_cur = lat; reqcnt = 0; log_q.delete();
        drive(op, a, sd);
        #1;
        stalls = 0; to_seen = 1'b0; bub_bad = 1'b0;
        for (int k = 0; k < 40 && s; k++) begin
            service();
            s = stall_out;
            if (mem_timeout) begin
                to_seen = 1'b1;
                if (dmem_read || dmem_write) bub_bad = 1'b1;
            end
            @(negedge clk); #1;
            if (s) begin
                stalls++;
                if (wb_valid) bub_bad = 1'b1;
            end
        end
        if (s) begin
            tests++; fails++;
            $display("FAIL stall_bound: stall still high after 40 cycles");
        end
        release_in();
    endtask

    task automatic chk_wb(input string nm);
        chk({nm, "_pc"}, wb_pc, cur_pc);
        chk({nm, "_ir"}, wb_ir, cur_ir);
        chk({nm, "_ctrl"}, wb_ctrl, cur_ctrl);
    endtask

    initial begin
        int st; bit to, bb; req_t r;
        op_e op; logic [15:0] a, sd, aw, w0, p, ed; int lat, es; bit eto;
        tv[0]  = '{LDR, 16'h1002, 16'h0000, 2, 16'h1002, 16'hBEEF, 16'h0, 16'h0, 3, 16'hBEEF, 16'h1002, 16'h0, 2'b11, 1, 1'b0};
        tv[1]  = '{LDB, 16'h2001, 16'h0000, 1, 16'h2000, 16'h12AB, 16'h0, 16'h0, 2, 16'h0012, 16'h2000, 16'h0, 2'b11, 1, 1'b0};
        tv[2]  = '{STB, 16'h2001, 16'h00CD, 1, 16'h0, 16'h0, 16'h0, 16'h0, 2, 16'h0, 16'h2000, 16'hCDCD, 2'b10, 1, 1'b0};
        tv[3]  = '{LDI, 16'h3000, 16'h0000, 1, 16'h3000, 16'h4000, 16'h4000, 16'h5555, 3, 16'h5555, 16'h4000, 16'h0, 2'b11, 2, 1'b0};
        tv[4]  = '{STI, 16'h3000, 16'h7777, 2, 16'h3000, 16'h4002, 16'h0, 16'h0, 5, 16'h0, 16'h4002, 16'h7777, 2'b11, 2, 1'b0};
        tv[5]  = '{NOP, 16'h1234, 16'h0000, 1, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 2'b00, 0, 1'b0};
        tv[6]  = '{LDR, 16'h1003, 16'h0000, 4, 16'h0, 16'h0, 16'h0, 16'h0, 5, 16'hBEEF, 16'h1002, 16'h0, 2'b11, 1, 1'b0};
        tv[7]  = '{STB, 16'h2000, 16'h12AB, 1, 16'h0, 16'h0, 16'h0, 16'h0, 2, 16'h0, 16'h2000, 16'hABAB, 2'b01, 1, 1'b0};
        tv[8]  = '{LDB, 16'h2001, 16'h0000, 3, 16'h0, 16'h0, 16'h0, 16'h0, 4, 16'h00CD, 16'h2000, 16'h0, 2'b11, 1, 1'b0};
        tv[9]  = '{LDR, 16'h1002, 16'h0000, 0, 16'h0, 16'h0, 16'h0, 16'h0, 5, 16'h0, 16'h1002, 16'h0, 2'b11, 1, 1'b1};
        tv[10] = '{LDR, 16'h4002, 16'h0000, 1, 16'h0, 16'h0, 16'h0, 16'h0, 2, 16'h7777, 16'h4002, 16'h0, 2'b11, 1, 1'b0};
        reset = 1'b1; release_in(); dmem_resp = 1'b0; dmem_rdata = '0;
        exmem_addr = '0; exmem_sdata = '0; exmem_pc = '0; exmem_ir = '0; exmem_ctrl = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_en, stall_out, mem_timeout,
                              wb_valid, wb_alu_out, wb_mem_data, wb_pc, wb_ir, wb_ctrl}, 128'h0);
        @(negedge clk); reset = 1'b0; #1;

        for (int i = 0; i < 11; i++) begin
            if (tv[i].pa != 0) poke(tv[i].pa, tv[i].pd);
            if (tv[i].qa != 0) poke(tv[i].qa, tv[i].qd);
            run(tv[i].op, tv[i].a, tv[i].sd, tv[i].lat, st, to, bb);
            chk($sformatf("v%0d_stalls", i), st, tv[i].es);
            chk($sformatf("v%0d_valid", i), wb_valid, !tv[i].eto);
            chk($sformatf("v%0d_timeout_seen", i), to, tv[i].eto);
            chk($sformatf("v%0d_bubble", i), bb, 1'b0);
            chk($sformatf("v%0d_nreq", i), log_q.size(), tv[i].n);
            if (log_q.size() > 0 && tv[i].n > 0) begin
                r = log_q[$];
                chk($sformatf("v%0d_last_addr", i), r.a, tv[i].la);
                chk($sformatf("v%0d_last_be", i), r.be, tv[i].lbe);
                chk($sformatf("v%0d_last_wr", i), r.wr, tv[i].op inside {STR, STB, STI});
                if (r.wr) chk($sformatf("v%0d_last_wdata", i), r.d, tv[i].lwd);
            end
            if (tv[i].eto) chk($sformatf("v%0d_pulse_end", i), mem_timeout, 1'b0);
            else chk_wb($sformatf("v%0d", i));
            if (!tv[i].eto && tv[i].op inside {LDR, LDB, LDI})
                chk($sformatf("v%0d_data", i), wb_mem_data, tv[i].ed);
        end

        // Reset while the second LDI phase is outstanding.
        poke(16'h3000, 16'h4000);
        lat_cur = 3; reqcnt = 0; log_q.delete();
        drive(LDI, 16'h3000, 16'h0000);
        #1;
        for (int k = 0; k < 20 && log_q.size() < 2; k++) begin
            service();
            if (log_q.size() < 2) begin @(negedge clk); #1; end
        end
        chk("rst_pre_read", dmem_read, 1'b1);
        chk("rst_pre_addr", dmem_address, 16'h4000);
        reset = 1'b1; release_in(); dmem_resp = 1'b0;
        #1;
        chk("rst_read_drop", dmem_read, 1'b0);
        chk("rst_outputs", {dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_en, stall_out, mem_timeout,
                            wb_valid, wb_alu_out, wb_mem_data, wb_pc, wb_ir, wb_ctrl}, 128'h0);
        @(negedge clk); reset = 1'b0; #1;
        run(NOP, 16'h0042, 16'h0000, 1, st, to, bb);
        chk("post_rst_stalls", st, 0);
        chk("post_rst_valid", wb_valid, 1'b1);
        chk("post_rst_noretry", log_q.size(), 0);
        chk("post_rst_alu", wb_alu_out, 16'h0042);

        for (int i = 0; i < 250; i++) begin
            op  = op_e'($urandom_range(0, 6));
            a   = 16'h0100 + 16'($urandom_range(0, 31));
            sd  = 16'($urandom);
            lat = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4);
            if (op == NOP) lat = 1;
            eto = (lat == 0);
            aw  = {a[15:1], 1'b0};
            w0  = mrd(aw);
            p   = {w0[15:1], 1'b0};
            ed  = 16'h0;
            exp_q.delete();
            case (op)
                LDR: begin exp_q.push_back('{1'b0, aw, 16'h0, 2'b11}); ed = w0; end
                LDB: begin exp_q.push_back('{1'b0, aw, 16'h0, 2'b11}); ed = {8'h00, a[0] ? w0[15:8] : w0[7:0]}; end
                STR: exp_q.push_back('{1'b1, aw, sd, 2'b11});
                STB: exp_q.push_back('{1'b1, aw, {sd[7:0], sd[7:0]}, a[0] ? 2'b10 : 2'b01});
                LDI: begin exp_q.push_back('{1'b0, aw, 16'h0, 2'b11}); exp_q.push_back('{1'b0, p, 16'h0, 2'b11}); ed = mrd(p); end
                STI: begin exp_q.push_back('{1'b0, aw, 16'h0, 2'b11}); exp_q.push_back('{1'b1, p, sd, 2'b11}); end
                default: ;
            endcase
            if (eto) while (exp_q.size() > 1) void'(exp_q.pop_back());
            es = (op == NOP) ? 0 : eto ? 1 + MW : 1 + lat * ((op == LDI || op == STI) ? 2 : 1);
            run(op, a, sd, lat, st, to, bb);
            chk($sformatf("r%0d_stalls", i), st, es);
            chk($sformatf("r%0d_valid", i), wb_valid, !eto);
            chk($sformatf("r%0d_timeout_seen", i), to, eto);
            chk($sformatf("r%0d_bubble", i), bb, 1'b0);
            chk($sformatf("r%0d_nreq", i), log_q.size(), exp_q.size());
            for (int j = 0; j < exp_q.size() && j < log_q.size(); j++)
                chk($sformatf("r%0d_req%0d", i, j), {log_q[j].wr, log_q[j].a, exp_q[j].wr ? log_q[j].d : 16'h0, log_q[j].be},
                    {exp_q[j].wr, exp_q[j].a, exp_q[j].d, exp_q[j].be});
            if (!eto) begin
                chk_wb($sformatf("r%0d", i));
                chk($sformatf("r%0d_alu", i), wb_alu_out, a);
                if (op inside {LDR, LDB, LDI}) chk($sformatf("r%0d_data", i), wb_mem_data, ed);
            end
            if ($urandom_range(0, 3) == 0) begin
                lat_cur = 1;
                service();
                @(negedge clk); #1;
                chk($sformatf("r%0d_idle_valid", i), wb_valid, 1'b0);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
